// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM state encoding and register window offsets for irq_ctrl
package irq_pkg;
    typedef enum logic [1:0] {IDLE, ENTER, INSVC, RETURN} state_e;
    localparam logic [3:0] OFF_CTRL  = 4'h0;
    localparam logic [3:0] OFF_PEND  = 4'h4;
    localparam logic [3:0] OFF_CAUSE = 4'h8;
    localparam logic [3:0] OFF_EPC   = 4'hC;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder over NIRQ request lines
module irq_prio_enc #(
    parameter int NIRQ = 4
) (
    input  logic [NIRQ-1:0] req_i,
    output logic [3:0]      idx_o,
    output logic            valid_o
);
    always_comb begin
        idx_o = '0;
        for (int i = NIRQ - 1; i >= 0; i--) if (req_i[i]) idx_o = 4'(i);
    end
    assign valid_o = |req_i;
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-triggered vectored interrupt controller that redirects the datapath PC into handlers and back on mret
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          NIRQ    = 4,
    parameter logic [31:0] BASE    = 32'hFFFF_0000,
    parameter logic [31:0] VECBASE = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq,
    input  logic [31:0]     pc,
    input  logic            mret,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    input  logic            memwrite,
    output logic [31:0]     rdata,
    output logic            rhit,
    output logic            ISRsel,
    output logic [31:0]     ISR,
    output logic            suspend,
    output logic            squash
);
    state_e          state_q;
    logic [NIRQ-1:0] mask_q, pend_q, pend_d, irq_q, req, sw_clr, hw_clr;
    logic            gie_q, req_vld, take, wr_ctrl, wr_pend;
    logic [3:0]      cause_q, idx_q, idx, off;
    logic [31:0]     epc_q;
    logic            unused_ok;

    irq_prio_enc #(.NIRQ(NIRQ)) u_enc (
        .req_i   (req),
        .idx_o   (idx),
        .valid_o (req_vld)
    );

    assign req     = pend_q & mask_q;
    assign take    = state_q == IDLE && gie_q && req_vld;
    assign rhit    = addr[31:4] == BASE[31:4];
    assign off     = {addr[3:2], 2'b00};
    assign wr_ctrl = memwrite && rhit && off == OFF_CTRL;
    assign wr_pend = memwrite && rhit && off == OFF_PEND;
    assign sw_clr  = wr_pend ? wdata[NIRQ-1:0] : '0;
    assign hw_clr  = state_q == ENTER ? NIRQ'(1) << idx_q : '0;
    // New edges are OR-ed in last so they survive both the software and the taken clear
    assign pend_d  = (pend_q & ~sw_clr & ~hw_clr) | (irq & ~irq_q);

    assign rdata = !rhit              ? '0 :
                   off == OFF_CTRL    ? {gie_q, 31'(mask_q)} :
                   off == OFF_PEND    ? 32'(pend_q) :
                   off == OFF_CAUSE   ? 32'(cause_q) : epc_q;

    assign ISRsel  = state_q == ENTER || state_q == RETURN;
    assign suspend = state_q == ENTER;
    assign squash  = ISRsel;
    assign ISR     = state_q == ENTER  ? VECBASE + {24'b0, idx_q, 4'b0} :
                     state_q == RETURN ? epc_q : '0;

    assign unused_ok = ^{wdata[30:NIRQ], addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            gie_q   <= 1'b0;
            pend_q  <= '0;
            irq_q   <= '0;
            cause_q <= '0;
            idx_q   <= '0;
            epc_q   <= '0;
        end else begin
            irq_q  <= irq;
            pend_q <= pend_d;
            if (wr_ctrl) begin
                mask_q <= wdata[NIRQ-1:0];
                gie_q  <= wdata[31];
            end
            case (state_q)
                IDLE: if (take) begin
                    state_q <= ENTER;
                    idx_q   <= idx;
                end
                ENTER: begin
                    state_q <= INSVC;
                    epc_q   <= pc;
                    cause_q <= idx_q;
                end
                INSVC: if (mret) state_q <= RETURN;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed vector table, hand-written reset/GIE sequences and a randomized run against a behavioural model
module tb_irq_ctrl;
    localparam logic [31:0] B   = 32'hFFFF_0000;
    localparam logic [31:0] VEC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset, mret, memwrite, rhit, ISRsel, suspend, squash;
    logic [3:0]  irq;
    logic [31:0] pc, addr, wdata, rdata, ISR;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    irq_ctrl dut (
        .clk(clk), .reset(reset), .irq(irq), .pc(pc), .mret(mret),
        .addr(addr), .wdata(wdata), .memwrite(memwrite), .rdata(rdata),
        .rhit(rhit), .ISRsel(ISRsel), .ISR(ISR), .suspend(suspend), .squash(squash)
    );

    typedef struct {
        logic [31:0] rst, irq, mret, pc, addr, wdata, we, kind, isr, rd;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [31:0] r, i, m, p, a, w, we, k, isr, rd);
        vec_t v;
        v.rst = r; v.irq = i; v.mret = m; v.pc = p; v.addr = a;
        v.wdata = w; v.we = we; v.kind = k; v.isr = isr; v.rd = rd;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [31:0] r, i, m, p, a, w, we);
        reset = r[0]; irq = i[3:0]; mret = m[0]; pc = p; addr = a; wdata = w; memwrite = we[0];
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [67:0] got, input logic [67:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // kind 1 = entry redirect, kind 2 = return redirect, else quiet
    function automatic logic [34:0] redir(input logic [31:0] k, input logic [31:0] isr);
        return k == 1 ? {1'b1, isr, 2'b11} : k == 2 ? {1'b1, isr, 2'b01} : 35'b0;
    endfunction

    function automatic logic inwin(input logic [31:0] a);
        return a[31:4] == B[31:4];
    endfunction

    function automatic logic [67:0] outs();
        return {ISRsel, ISR, suspend, squash, rhit, rdata};
    endfunction

    logic [3:0]  m_mask, m_pend, m_prev, m_cause, m_idx, cur, irqv, np, req;
    logic        m_gie, ent, svc, ret, r, m, we, hit;
    logic [31:0] m_epc, a, w, p, rd;

    initial begin
        //  rst irq mret pc      addr      wdata          we kind isr      rd
        add(0, 0,  0,  0,      B,        32'h8000_0001, 1, 0,   0,       0);
        add(0, 0,  0,  0,      B,        0,             0, 0,   0,       32'h8000_0001);
        add(0, 1,  0,  0,      0,        0,             0, 0,   0,       0);
        add(0, 1,  0,  'h40,   B+4,      0,             0, 0,   0,       1);
        add(0, 0,  0,  'h44,   B+4,      0,             0, 1,   'h100,   1);
        add(0, 0,  0,  0,      B+12,     0,             0, 0,   0,       'h44);
        add(0, 0,  1,  0,      B+8,      0,             0, 0,   0,       0);
        add(0, 0,  0,  0,      B+4,      0,             0, 2,   'h44,    0);
        add(0, 0,  0,  0,      0,        0,             0, 0,   0,       0);
        add(0, 0,  0,  0,      B,        32'h8000_000A, 1, 0,   0,       32'h8000_0001);
        add(0, 'hA,0,  0,      0,        0,             0, 0,   0,       0);
        add(0, 'hA,0,  0,      B+4,      0,             0, 0,   0,       'hA);
        add(0, 'hA,0,  'h80,   B+4,      0,             0, 1,   'h110,   'hA);
        add(0, 'hA,0,  0,      B+4,      0,             0, 0,   0,       'h8);
        add(0, 'hA,0,  0,      B+8,      0,             0, 0,   0,       1);
        add(0, 'h2,0,  0,      B+4,      8,             1, 0,   0,       'h8);
        add(0, 'hA,0,  0,      B+4,      0,             0, 0,   0,       0);
        add(0, 'hA,1,  0,      B+4,      0,             0, 0,   0,       'h8);
        add(0, 'hA,0,  0,      B+12,     0,             0, 2,   'h80,    'h80);
        add(0, 'hA,0,  0,      0,        0,             0, 0,   0,       0);
        add(0, 'hA,0,  'h200,  0,        0,             0, 1,   'h130,   0);
        add(0, 'hA,0,  0,      B+8,      0,             0, 0,   0,       3);
        add(0, 'hA,1,  0,      B+12,     0,             0, 0,   0,       'h200);
        add(0, 'hA,0,  0,      0,        0,             0, 2,   'h200,   0);
        add(0, 'hA,0,  0,      B+4,      0,             0, 0,   0,       0);
        add(0, 'hB,0,  0,      B+4,      1,             1, 0,   0,       0);
        add(0, 'hB,0,  0,      B+4,      0,             0, 0,   0,       1);
        add(0, 'hB,0,  0,      B+8,      'hFFFF,        1, 0,   0,       3);
        add(0, 'hB,0,  0,      B+8,      0,             0, 0,   0,       3);
        add(0, 'hB,0,  0,      B+12,     32'hFFFF_FFFF, 1, 0,   0,       'h200);
        add(0, 'hB,0,  0,      B+12,     0,             0, 0,   0,       'h200);
        add(0, 'hB,0,  0,      B+16,     0,             0, 0,   0,       0);
        add(0, 'hB,0,  0,      B-4,      0,             0, 0,   0,       0);
        add(0, 'hB,1,  0,      0,        0,             0, 0,   0,       0);
        add(0, 'hB,0,  0,      0,        0,             0, 0,   0,       0);
        add(0, 'hA,0,  0,      B,        32'h8000_0003, 1, 0,   0,       32'h8000_000A);
        add(0, 'hA,0,  0,      B,        0,             0, 0,   0,       32'h8000_0003);
        add(0, 'hB,0,  'h300,  B+4,      0,             0, 1,   'h100,   1);
        add(0, 'hB,0,  0,      B+4,      0,             0, 0,   0,       1);
        add(0, 'hB,1,  0,      B+12,     0,             0, 0,   0,       'h300);
        add(0, 'hB,0,  0,      0,        0,             0, 2,   'h300,   0);
        add(0, 'hB,0,  0,      B+4,      0,             0, 0,   0,       1);
        add(1, 0,  0,  'h500,  0,        0,             0, 1,   'h100,   0);
        add(0, 0,  0,  0,      B,        0,             0, 0,   0,       0);
        add(0, 0,  0,  0,      B+4,      0,             0, 0,   0,       0);
        add(0, 0,  0,  0,      B+8,      0,             0, 0,   0,       0);
        add(0, 0,  0,  0,      B+12,     0,             0, 0,   0,       0);
        add(0, 0,  0,  0,      0,        0,             0, 0,   0,       0);

        drive(1, 0, 0, 0, B, 0, 0);
        cyc();
        cyc();
        chk("reset_state", outs(), {1'b0, 32'b0, 1'b0, 1'b0, 1'b1, 32'b0});

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].irq, tbl[i].mret, tbl[i].pc, tbl[i].addr, tbl[i].wdata, tbl[i].we);
            #1;
            chk($sformatf("vec%0d_redir", i), 68'({ISRsel, ISR, suspend, squash}), 68'(redir(tbl[i].kind, tbl[i].isr)));
            chk($sformatf("vec%0d_read", i), 68'({rhit, rdata}), 68'({inwin(tbl[i].addr), tbl[i].rd}));
            cyc();
        end

        // GIE off holds a pending, unmasked source; enabling GIE takes it two cycles later
        drive(0, 0, 0, 0, B, 1, 1);
        cyc();
        drive(0, 1, 0, 0, 0, 0, 0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, B + 4, 0, 0);
            #1;
            chk("gie_off_hold", 68'({ISRsel, rdata}), 68'({1'b0, 32'h1}));
            cyc();
        end
        drive(0, 0, 0, 0, B, 32'h8000_0001, 1);
        #1;
        chk("gie_on_write", 68'(ISRsel), 68'(0));
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("gie_on_take", 68'({ISRsel, suspend}), 68'(0));
        cyc();
        drive(0, 0, 0, 32'h1234, 0, 0, 0);
        #1;
        chk("gie_on_enter", 68'({ISRsel, ISR, suspend, squash}), 68'({1'b1, 32'h100, 2'b11}));
        cyc();
        drive(0, 0, 1, 0, B + 12, 0, 0);
        #1;
        chk("insvc_epc", 68'(rdata), 68'(32'h1234));
        cyc();
        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("return_pre_rst", 68'({ISRsel, ISR, suspend, squash}), 68'({1'b1, 32'h1234, 2'b01}));
        cyc();
        drive(0, 0, 0, 0, B + 12, 0, 0);
        #1;
        chk("return_rst_out", outs(), {1'b0, 32'b0, 1'b0, 1'b0, 1'b1, 32'b0});
        cyc();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, B + 32'(4 * k), 0, 0);
            #1;
            chk("return_rst_quiet", 68'({ISRsel, rdata}), 68'(0));
            cyc();
        end

        m_mask = '0; m_pend = '0; m_prev = '0; m_cause = '0; m_idx = '0; m_epc = '0;
        m_gie = 1'b0; ent = 1'b0; svc = 1'b0; ret = 1'b0; cur = '0;
        for (int n = 0; n < 3000; n++) begin
            r = (n == 0) || ($urandom_range(0, 199) == 0);
            irqv = cur ^ (($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0);
            cur = irqv;
            m = $urandom_range(0, 4) == 0;
            we = $urandom_range(0, 3) == 0;
            a = ($urandom_range(0, 9) < 7) ? B + 32'($urandom_range(0, 15)) : 32'($urandom);
            w = $urandom;
            if (a[3:2] == 2'd0 && $urandom_range(0, 3) != 0) w[31] = 1'b1;
            p = $urandom;
            reset = r; irq = irqv; mret = m; pc = p; addr = a; wdata = w; memwrite = we;
            #1;
            hit = a[31:4] == B[31:4];
            case (a[3:2])
                2'd0: rd = {m_gie, 27'b0, m_mask};
                2'd1: rd = 32'(m_pend);
                2'd2: rd = 32'(m_cause);
                default: rd = m_epc;
            endcase
            if (!hit) rd = '0;
            if (n > 0)
                chk($sformatf("rand%0d", n), outs(),
                    {ent | ret, ent ? VEC + 32'(m_idx) * 16 : ret ? m_epc : 32'b0, ent, ent | ret, hit, rd});
            if (r) begin
                m_mask = '0; m_pend = '0; m_prev = '0; m_cause = '0; m_idx = '0; m_epc = '0;
                m_gie = 1'b0; ent = 1'b0; svc = 1'b0; ret = 1'b0;
            end else begin
                req = m_pend & m_mask;
                np = m_pend;
                if (we && hit && a[3:2] == 2'd1) np = np & ~w[3:0];
                if (ent) np[m_idx[1:0]] = 1'b0;
                for (int j = 0; j < 4; j++) if (irqv[j] && !m_prev[j]) np[j] = 1'b1;
                if (ent) begin
                    m_epc = p; m_cause = m_idx; ent = 1'b0; svc = 1'b1;
                end else if (ret) begin
                    ret = 1'b0;
                end else if (svc) begin
                    if (m) begin svc = 1'b0; ret = 1'b1; end
                end else if (m_gie && req != 0) begin
                    for (int j = 3; j >= 0; j--) if (req[j]) m_idx = 4'(j);
                    ent = 1'b1;
                end
                if (we && hit && a[3:2] == 2'd0) begin
                    m_mask = w[3:0]; m_gie = w[31];
                end
                m_pend = np;
                m_prev = irqv;
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller for the RV32i core, directly upstream of the datapath. It drives the datapath's `ISRsel`, `ISR` and `suspend` inputs to redirect the PC into a handler, and keeps its own copy of the preempted PC. On `mret` it redirects the PC back to that address. Software controls it through a small memory-mapped register window decoded from the datapath's `aluout` and `writedata4`.

## Interface
Parameters:
- `NIRQ`, 4: number of interrupt sources, legal range 1..16.
- `BASE`, 32'hFFFF_0000: word-aligned base address of the register window.
- `VECBASE`, 32'h0000_0100: handler vector base. Vector for source i = `VECBASE + 16*i`.

Ports:
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `irq` in NIRQ: interrupt sources, synchronous to `clk`, rising-edge sensitive.
- `pc` in 32: current PC from the datapath.
- `mret` in 1: decoder flag, high while an mret instruction is at `pc`.
- `addr` in 32: data address (datapath `aluout`).
- `wdata` in 32: store data (datapath `writedata4`).
- `memwrite` in 1: store strobe.
- `rdata` out 32: register read data. Zero when `rhit` is 0.
- `rhit` out 1: `addr[31:4] == BASE[31:4]`. The external load mux selects `rdata` over memory.
- `ISRsel` out 1: PC redirect enable.
- `ISR` out 32: redirect target.
- `suspend` out 1: high only on entry.
- `squash` out 1: controller must suppress `regwrite` and `memwrite` this cycle.

## Operation
Register window (word offsets from `BASE`):
- +0 `CTRL`, RW: bits [NIRQ-1:0] are the mask; bit 31 is GIE. Reset value 0.
- +4 `PEND`: reads the pending bits. A store writes 1 to clear.
- +8 `CAUSE`, RO: index of the last taken source.
- +C `EPC`, RO: saved PC.

Edge detect:
- `irq_d <= irq` every cycle.
- Pending bit i is set when `irq[i] & ~irq_d[i]`.
- A hardware set wins over a software clear in the same cycle, and over the taken-clear in ENTER.

Take condition: `state==IDLE`, GIE set, and `PEND & mask` nonzero. The lowest index wins.

FSM states (registered):
- IDLE
  - `ISRsel=0`, `suspend=0`, `squash=0`.
  - Go to ENTER when the take condition holds.
- ENTER (exactly 1 cycle)
  - Outputs: `ISRsel=1`, `ISR=VECBASE+16*idx`, `suspend=1`, `squash=1`.
  - At the end of the cycle: `epc<=pc`, `cause<=idx`, clear pending[idx].
  - `idx` is the value latched on entering ENTER, not recomputed.
  - Go to INSVC.
- INSVC
  - No nesting: new edges only set pending.
  - On `mret` go to RETURN. Stores to the window still take effect.
- RETURN (exactly 1 cycle)
  - Outputs: `ISRsel=1`, `ISR=epc`, `squash=1`.
  - Go to IDLE.
  - A pending, unmasked source re-enters no earlier than the cycle after IDLE is reached.
- `mret` in IDLE, ENTER or RETURN is ignored.

Arithmetic and access rules:
- Vector offset is `{idx,4'b0}` zero-extended. No overflow is possible for NIRQ ≤ 16.
- Stores with `rhit` set and offset +8 or +C are ignored.
- Byte and halfword stores write the full register using `wdata` as presented.

Reset values:
- Outputs: `ISRsel`, `ISR`, `suspend`, `squash`, `rdata` are all 0.
- Registers: `CTRL`, `PEND`, `CAUSE`, `EPC`, `irq_d` are 0. State is IDLE.
- Reset asserted in any state, including mid-ENTER or RETURN, forces these values on the next edge. Reset wins over every other update.

## Timing
- Edge at `irq[i]` sampled at clock edge n → pending set after edge n.
- ENTER occupies cycle n+1, provided the take condition holds in that cycle.
- Handler fetch occurs at edge n+2. Minimum latency is 2 cycles.
- `mret` seen in INSVC at cycle m → RETURN in cycle m+1 → pc = epc after edge m+2.
- Register reads are combinational on `addr`.
- Register writes take effect at the edge ending the store cycle.
- All `ISR`, `ISRsel`, `suspend`, `squash` outputs decode from state registers (plus `idx`/`epc`) only. There are no combinational paths from `irq` or `mret`.

## Structure
- Package `irq_pkg`: state enum (IDLE, ENTER, INSVC, RETURN) and register offset constants (`OFF_CTRL`, `OFF_PEND`, `OFF_CAUSE`, `OFF_EPC`).
- Sub-module `irq_prio_enc`: parameterised lowest-index priority encoder, NIRQ-bit request in, 4-bit index plus valid out.

## Test plan
- Reset, then store 32'h8000_0001 to `BASE`, then pulse `irq[0]` high at cycle 10 → ENTER in cycle 12 with `ISR`=32'h100, `suspend`=`squash`=1, then EPC = pc at cycle 12.
- `irq[1]` and `irq[3]` rise together, mask 4'hA, GIE=1 → source 1 taken (`ISR`=32'h110), CAUSE=1, `PEND` reads 4'h8.
- In INSVC, raise `irq[3]`, then assert `mret` → RETURN with `ISR`=EPC, then IDLE, then ENTER for source 3 (`ISR`=32'h130) one cycle later.
- Store 1 to `BASE+4` in the same cycle as a new `irq[0]` edge → `PEND[0]` stays 1.
- Assert `reset` during ENTER → next cycle all outputs are 0, state IDLE, `CTRL`/`PEND` 0, and no redirect follows.
